hit_input_conditioner: RTL and testbench
========================================

Name: hit_input_conditioner

Overview:
- Front end for the mole-hit buttons. It synchronises and debounces N_CH active-low raw hit inputs and produces clean single-cycle press and release pulses.
- It queues press events so that simultaneous hits are never lost. Queued events are delivered one at a time to the game/scoring stage over a valid/ready handshake.
- It sits directly upstream of the mole-timing/scoring logic. That logic consumes hit_valid/hit_idx instead of edge-detecting raw pins itself.

Parameters:
- N_CH, 4, number of hit channels (one per mole).
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised level must persist before it is accepted (10 ms at 100 MHz); minimum 2.
- IDX_W, 2, width of hit_idx; equals clog2(N_CH).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous, active-low reset
- hit_raw  in  N_CH  raw button/sensor levels, asynchronous, active-low (0 = pressed)
- pressed  out  N_CH  debounced level per channel, 1 = held
- press_pulse  out  N_CH  one-cycle pulse per accepted press
- release_pulse  out  N_CH  one-cycle pulse per accepted release
- hit_valid  out  1  queued press event available
- hit_idx  out  IDX_W  channel of the presented event
- hit_ready  in  1  consumer accepts the event this cycle
- overrun  out  1  sticky: a press was dropped

Behaviour:
- Reset is sampled on the clk rising edge while rst_n=0.
  - Both sync stages and stable_q reset to all-1 (released).
  - Debounce counters reset to 0; pending resets to 0.
  - hit_valid, hit_idx, press_pulse, release_pulse, overrun and pressed all reset to 0.
  - Reset mid-operation discards all pending and presented events with no pulses.
- Synchroniser: two flops per channel, giving sync2.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYCLES):
  - If sync2 == stable_q, cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, then stable_q <= sync2 and cnt <= 0; else cnt <= cnt+1.
  - Any return to stable_q restarts the count. Glitches shorter than DEBOUNCE_CYCLES are invisible.
- pressed = ~stable_q.
- Pulses, registered:
  - press_pulse[i]=1 for exactly the one cycle after the edge where stable_q[i] goes 1->0.
  - release_pulse[i]=1 likewise for 0->1.
- Latency: hit_raw low, first sampled at edge 0, gives sync2 low after edge 1; stable_q and press_pulse update at edge DEBOUNCE_CYCLES+1.
- Pending queue (pending[N_CH], registered):
  - press_pulse[i] sets pending[i] at the next edge.
  - If pending[i] is already 1 and is not being loaded that cycle, overrun <= 1. overrun is cleared only by reset.
- Output slot (hit_valid, hit_idx registered):
  - At each edge where hit_valid==0 or hit_ready==1, the slot loads the lowest-index set pending bit. That bit is cleared and hit_valid <= 1.
  - If nothing is pending, hit_valid <= 0.
  - While hit_valid=1 and hit_ready=0, hit_valid and hit_idx hold stable regardless of new presses.
  - A transfer occurs on an edge with hit_valid && hit_ready. Back-to-back transfers run at one per cycle.
- Simultaneous events:
  - Load of channel i and a new press on channel i in the same cycle: pending[i] ends at 1 (set wins), no overrun.
  - Presses on multiple channels in one cycle: all set pending, then deliver in ascending index order.
- hit_ready while hit_valid=0 is ignored.
- End-to-end latency from press_pulse to hit_valid is 2 edges when the slot is free: pending is set, then the slot loads.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 for 3 cycles with hit_raw toggling -> all outputs 0, pressed=0000; after release, no pulses while hit_raw=1111.
- Clean press, ch0 held low from edge 0, hit_ready=1 -> press_pulse[0] high only in the cycle after edge 5; pressed[0]=1; hit_valid=1, hit_idx=0 for exactly 1 cycle; release after 20 cycles gives one release_pulse[0].
- Bounce: ch2 low 3 cycles, high 1, low 3, high -> no press_pulse, pressed[2]=0, hit_valid never 1.
- Simultaneous presses: ch3 and ch1 press together, hit_ready=0 for 10 cycles -> hit_idx=1 held stable with hit_valid=1; then hit_ready=1 -> idx 1, then idx 3 on consecutive edges, then hit_valid=0; overrun=0.
- Overrun: ch0 presented with hit_ready=0, ch2 pressed then released and pressed again -> overrun=1 after the second press_pulse[2]; on ready, events are idx 0, then idx 2 once only.
- Reset mid-queue: ch1 and ch2 pending, assert rst_n=0 for 1 cycle -> hit_valid=0, overrun=0; no events delivered after reset.

Source files
------------

// File: rtl/hit_input_conditioner.sv
// Mole-hit button front end: two-flop synchroniser, per-channel debounce,
// registered press/release pulses and a one-slot valid/ready event queue.
module hit_input_conditioner #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int IDX_W           = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  hit_raw,
    output logic [N_CH-1:0]  pressed,
    output logic [N_CH-1:0]  press_pulse,
    output logic [N_CH-1:0]  release_pulse,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_idx,
    input  logic             hit_ready,
    output logic             overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  sync1_reg;
    logic [N_CH-1:0]  sync2_reg;
    logic [N_CH-1:0]  stable_reg;
    logic [N_CH-1:0]  stable_next;
    logic [N_CH-1:0]  press_pulse_reg;
    logic [N_CH-1:0]  release_pulse_reg;
    logic [N_CH-1:0]  pending_reg;
    logic [N_CH-1:0]  pending_next;
    logic [N_CH-1:0]  load_mask;
    logic             hit_valid_reg;
    logic [IDX_W-1:0] hit_idx_reg;
    logic             overrun_reg;
    logic             slot_free;
    logic             found;
    logic [IDX_W-1:0] sel_idx;

    // Raw levels are active-low; idle/reset value is all-1 (released).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= hit_raw;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             differs;

            assign differs         = sync2_reg[gi] != stable_reg[gi];
            assign stable_next[gi] = (differs && cnt_reg == CNT_LAST) ? sync2_reg[gi]
                                                                      : stable_reg[gi];

            // Any return to the accepted level restarts the count.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!differs || cnt_reg == CNT_LAST) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_reg        <= '1;
            press_pulse_reg   <= '0;
            release_pulse_reg <= '0;
        end else begin
            stable_reg        <= stable_next;
            press_pulse_reg   <= stable_reg & ~stable_next;
            release_pulse_reg <= ~stable_reg & stable_next;
        end
    end

    // Lowest-index pending bit wins the output slot.
    always_comb begin
        slot_free = !hit_valid_reg || hit_ready;
        found     = 1'b0;
        sel_idx   = '0;
        load_mask = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        if (slot_free && found) begin
            load_mask = N_CH'(1) << sel_idx;
        end
        // A new press on the channel being loaded re-arms it (set wins).
        pending_next = (pending_reg & ~load_mask) | press_pulse_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg   <= '0;
            hit_valid_reg <= 1'b0;
            hit_idx_reg   <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (|(press_pulse_reg & pending_reg & ~load_mask)) begin
                overrun_reg <= 1'b1;
            end
            if (slot_free) begin
                hit_valid_reg <= found;
                if (found) begin
                    hit_idx_reg <= sel_idx;
                end
            end
        end
    end

    assign pressed       = ~stable_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign hit_valid     = hit_valid_reg;
    assign hit_idx       = hit_idx_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_hit_input_conditioner.sv
// Scoreboard bench for hit_input_conditioner with a short debounce window:
// expected event indices are queued at stimulus time and popped on each transfer.
module tb_hit_input_conditioner;

    localparam int N_CH  = 4;
    localparam int DEB   = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  hit_raw = '1;
    logic             hit_ready = 1'b1;
    logic [N_CH-1:0]  pressed;
    logic [N_CH-1:0]  press_pulse;
    logic [N_CH-1:0]  release_pulse;
    logic             hit_valid;
    logic [IDX_W-1:0] hit_idx;
    logic             overrun;

    hit_input_conditioner #(
        .N_CH(N_CH),
        .DEBOUNCE_CYCLES(DEB),
        .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hit_raw(hit_raw),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .hit_valid(hit_valid),
        .hit_idx(hit_idx),
        .hit_ready(hit_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [IDX_W-1:0] sb_q[$];

    // Written only by the monitor.
    int press_cnt[N_CH] = '{default: 0};
    int rel_cnt[N_CH]   = '{default: 0};
    int valid_cnt       = 0;
    logic [IDX_W-1:0] exp_idx;

    // Snapshots written only by the stimulus process.
    int snap_p;
    int snap_r;
    int snap_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: sample away from the active edge, count pulses, score transfers.
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (press_pulse[i])   press_cnt[i]++;
            if (release_pulse[i]) rel_cnt[i]++;
        end
        if (hit_valid) valid_cnt++;
        if (hit_valid && hit_ready) begin
            if (sb_q.size() == 0) begin
                check("xfer_extra", hit_valid, 0);
            end else begin
                exp_idx = sb_q.pop_front();
                check("xfer_idx", hit_idx, exp_idx);
                $display("xfer idx=%0d expected=%0d t=%0t", hit_idx, exp_idx, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with inputs toggling.
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            hit_raw = 4'($urandom);
        end
        @(negedge clk);
        check("rst_pressed", pressed, 0);
        check("rst_press_pulse", press_pulse, 0);
        check("rst_release_pulse", release_pulse, 0);
        check("rst_valid", hit_valid, 0);
        check("rst_idx", hit_idx, 0);
        check("rst_overrun", overrun, 0);
        cyc(1);
        rst_n   = 1'b1;
        hit_raw = '1;
        snap_p = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
        snap_r = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
        cyc(10);
        check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] - snap_p, 0);
        check("idle_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] - snap_r, 0);

        // Clean press on ch0; next posedge is edge 0.
        snap_p = press_cnt[0];
        snap_r = rel_cnt[0];
        hit_raw[0] = 1'b0;
        sb_q.push_back(2'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("cp_pulse", press_pulse[0], (k == DEB + 1));
            check("cp_valid", hit_valid, (k == DEB + 3));
        end
        check("cp_pressed", pressed, 4'b0001);
        cyc(10);
        hit_raw[0] = 1'b1;
        cyc(12);
        @(negedge clk);
        check("cp_press_cnt", press_cnt[0] - snap_p, 1);
        check("cp_release_cnt", rel_cnt[0] - snap_r, 1);
        check("cp_released", pressed, 0);

        // Bounce on ch2 shorter than the debounce window.
        cyc(1);
        snap_p = press_cnt[2];
        snap_v = valid_cnt;
        hit_raw[2] = 1'b0; cyc(3);
        hit_raw[2] = 1'b1; cyc(1);
        hit_raw[2] = 1'b0; cyc(3);
        hit_raw[2] = 1'b1; cyc(12);
        @(negedge clk);
        check("bn_press_cnt", press_cnt[2] - snap_p, 0);
        check("bn_pressed", pressed[2], 0);
        check("bn_valid_cnt", valid_cnt - snap_v, 0);

        // Simultaneous presses on ch1 and ch3 with a stalled consumer.
        cyc(1);
        hit_ready = 1'b0;
        hit_raw   = 4'b0101;
        sb_q.push_back(2'd1);
        sb_q.push_back(2'd3);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("sim_hold_valid", hit_valid, 1);
            check("sim_hold_idx", hit_idx, 1);
        end
        cyc(1);
        hit_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("sim_second_idx", hit_idx, 3);
        @(posedge clk);
        @(negedge clk);
        check("sim_drained", hit_valid, 0);
        check("sim_overrun", overrun, 0);
        cyc(1);
        hit_raw = '1;
        cyc(12);

        // Overrun: ch2 pressed twice while ch0 occupies the slot.
        hit_ready  = 1'b0;
        hit_raw[0] = 1'b0;
        sb_q.push_back(2'd0);
        cyc(10);
        snap_p = press_cnt[2];
        hit_raw[2] = 1'b0;
        sb_q.push_back(2'd2);
        cyc(10);
        hit_raw[2] = 1'b1;
        cyc(10);
        @(negedge clk);
        check("ov_before", overrun, 0);
        cyc(1);
        hit_raw[2] = 1'b0;
        cyc(10);
        @(negedge clk);
        check("ov_after", overrun, 1);
        check("ov_press_cnt", press_cnt[2] - snap_p, 2);
        cyc(1);
        hit_ready = 1'b1;
        cyc(5);
        @(negedge clk);
        check("ov_queue_empty", sb_q.size(), 0);
        check("ov_drained", hit_valid, 0);
        cyc(1);
        hit_raw = '1;
        cyc(12);

        // Reset while ch1 is presented and ch2 is pending.
        hit_ready = 1'b0;
        hit_raw   = 4'b1001;
        cyc(10);
        @(negedge clk);
        check("mr_valid_pre", hit_valid, 1);
        check("mr_idx_pre", hit_idx, 1);
        cyc(1);
        rst_n   = 1'b0;
        hit_raw = '1;
        cyc(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_valid", hit_valid, 0);
        check("mr_overrun", overrun, 0);
        check("mr_pressed", pressed, 0);
        snap_v = valid_cnt;
        cyc(1);
        hit_ready = 1'b1;
        cyc(20);
        @(negedge clk);
        check("mr_no_events", valid_cnt - snap_v, 0);
        check("mr_queue_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
